// File: rtl/barrett_reduce128.sv
//-----------------------------------------------------------------------------
// barrett_reduce128
//
// Pipelined Barrett reduction of a 2*W-bit product P by a run-time loaded
// W-bit modulus M (top bit set), using the precomputed mu = floor(2^(2W)/M).
// It takes one product per cycle with no stalls. A result appears exactly
// four edges after the edge that accepted the product.
//
// Pipeline:
//   S1  register P (and the range flag)
//   S2  q3 = (q1*mu) >> (W+1) with q1 = P >> (W-1); keep r1 = P[W:0]
//   S3  r2 = (q3*M) mod 2^(W+1)
//   S4  r  = (r1 - r2) mod 2^(W+1)
//   out two conditional subtractions of M, registered into out_data
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   in_data carries a product this cycle
//   in_data    product P (2*W bits), expected P < M*M
//   mod_load   load strobe for mod_in / mu_in
//   mod_in     modulus M (W bits), mod_in[W-1] must be 1
//   mu_in      floor(2^(2W)/M) (W+1 bits)
//   mod_ready  a modulus has been loaded since reset
//   busy       some of S1..S4 holds a valid entry
//   load_err   one-cycle pulse after a rejected mod_load
//   out_valid  out_data is valid
//   out_data   P mod M
//   err        result error flag, valid with out_valid
//
// Optional feature: define BARRETT_ERR_CHECK_EN to build the range checks that
// drive err. When it is not defined, err is tied low.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module barrett_reduce128 #(
  parameter int W = 64
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [2*W-1:0] in_data,
  input  logic           mod_load,
  input  logic [W-1:0]   mod_in,
  input  logic [W:0]     mu_in,
  output logic           mod_ready,
  output logic           busy,
  output logic           load_err,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           err
);

  logic [W-1:0]   mod_q;
  logic [W:0]     mu_q;
  logic           load_ok;
  logic           accept;

  logic           s1_valid, s2_valid, s3_valid, s4_valid;
  logic [2*W-1:0] s1_p;
  logic [W:0]     s2_q3, s2_r1;
  logic [W:0]     s3_r1, s3_r2;
  logic [W:0]     s4_r;

  logic [W:0]     q1;
  logic [W:0]     q3_next;
  logic [W:0]     q3_unused;
  logic [W:0]     r2_next;
  logic [W:0]     mod_ext;
  logic [W:0]     corr1, corr2;
  logic           corr_unused;
  logic [W-1:0]   out_next;

  // A load is only accepted with the pipe empty, so in-flight entries never
  // see a modulus change. A beat arriving with an accepted load uses the new M.
  assign busy    = s1_valid | s2_valid | s3_valid | s4_valid;
  assign load_ok = mod_load & ~busy & mod_in[W-1];
  assign accept  = in_valid & (mod_ready | load_ok);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mod_q     <= '0;
      mu_q      <= '0;
      mod_ready <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_err <= mod_load & ~load_ok;
      if (load_ok) begin
        mod_q     <= mod_in;
        mu_q      <= mu_in;
        mod_ready <= 1'b1;
      end
    end
  end

  // Full 2W+2-bit product of q1 and mu. Only the top W+1 bits form q3.
  assign q1                   = s1_p[2*W-1:W-1];
  assign {q3_next, q3_unused} = {{(W+1){1'b0}}, q1} * {{(W+1){1'b0}}, mu_q};

  // Only the low W+1 bits of q3*M matter, because the difference is taken mod 2^(W+1).
  assign mod_ext = {1'b0, mod_q};
  assign r2_next = s2_q3 * mod_ext;

  // The remainder after S4 is below 3M, so two conditional subtractions finish it.
  assign corr1                 = (s4_r  >= mod_ext) ? (s4_r  - mod_ext) : s4_r;
  assign corr2                 = (corr1 >= mod_ext) ? (corr1 - mod_ext) : corr1;
  assign {corr_unused, out_next} = corr2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s4_valid  <= 1'b0;
      out_valid <= 1'b0;
      s1_p      <= '0;
      s2_q3     <= '0;
      s2_r1     <= '0;
      s3_r1     <= '0;
      s3_r2     <= '0;
      s4_r      <= '0;
      out_data  <= '0;
    end else begin
      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      s4_valid  <= s3_valid;
      out_valid <= s4_valid;
      if (accept) begin
        s1_p <= in_data;
      end
      if (s1_valid) begin
        s2_q3 <= q3_next;
        s2_r1 <= s1_p[W:0];
      end
      if (s2_valid) begin
        s3_r1 <= s2_r1;
        s3_r2 <= r2_next;
      end
      if (s3_valid) begin
        s4_r <= s3_r1 - s3_r2;
      end
      if (s4_valid) begin
        out_data <= out_next;
      end
    end
  end

`ifdef BARRETT_ERR_CHECK_EN
  logic [W-1:0] mod_eff;
  logic         s1_flag, s2_flag, s3_flag, s4_flag;

  // The range check at S1 must use the modulus loaded on this same edge.
  assign mod_eff = load_ok ? mod_in : mod_q;

  // P[2W-1:W] >= M is necessary for P >= M*M. The flag travels with its entry.
  // A remainder still >= M after both corrections is flagged too.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_flag <= 1'b0;
      s2_flag <= 1'b0;
      s3_flag <= 1'b0;
      s4_flag <= 1'b0;
      err     <= 1'b0;
    end else begin
      s1_flag <= accept & (in_data[2*W-1:W] >= mod_eff);
      s2_flag <= s1_flag;
      s3_flag <= s2_flag;
      s4_flag <= s3_flag;
      err     <= s4_valid & (s4_flag | (corr2 >= mod_ext));
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_barrett_reduce128.sv
`timescale 1ns/1ps

module tb_barrett_reduce128;

  localparam logic [63:0] MT  = 64'hFFFF_FFFF_FFFF_FFC5;
  localparam logic [64:0] MUT = 65'h1_0000_0000_0000_003B;
`ifdef BARRETT_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic [127:0]  in_data;
  logic          mod_load;
  logic [63:0]   mod_in;
  logic [64:0]   mu_in;
  logic          mod_ready;
  logic          busy;
  logic          load_err;
  logic          out_valid;
  logic [63:0]   out_data;
  logic          err;

  barrett_reduce128 #(.W(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .mod_load  (mod_load),
    .mod_in    (mod_in),
    .mu_in     (mu_in),
    .mod_ready (mod_ready),
    .busy      (busy),
    .load_err  (load_err),
    .out_valid (out_valid),
    .out_data  (out_data),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard entry: the cycle on which the result is due and what it must be.
  typedef struct {
    int          due;
    logic [63:0] data;
    logic        chk;
    logic        e;
  } exp_t;

  typedef struct {
    logic [127:0] p;
    logic [63:0]  want;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[5];
  int          cyc;
  int          total;
  int          bad;
  logic        model_ready;
  logic [63:0] model_m;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [64:0] mu_of(input logic [63:0] m);
    logic [128:0] num;
    logic [128:0] q;
    num = 129'd1 << 128;
    q   = num / {65'd0, m};
    return q[64:0];
  endfunction

  function automatic logic [63:0] rand_mod();
    logic [63:0] m;
    m = {3'b100, 29'($urandom), $urandom};
    m[0] = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] rand_prod(input logic [63:0] m);
    logic [127:0] r;
    logic [127:0] mm;
    r  = {$urandom, $urandom, $urandom, $urandom};
    mm = {64'd0, m} * {64'd0, m};
    return r % mm;
  endfunction

  // One clock: wait for the edge, then check outputs against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("out_valid", 128'(out_valid), 128'(1'b1));
      if (e.chk) chk("out_data", 128'(out_data), 128'(e.data));
      chk("err", 128'(err), 128'(e.e));
    end else begin
      chk("out_valid_idle", 128'(out_valid), 128'(1'b0));
    end
    chk("busy", 128'(busy), 128'(sb.size() > 0));
    chk("mod_ready", 128'(mod_ready), 128'(model_ready));
  endtask

  // mode 0: model result, mode 1: use want, mode 2: do not check data.
  task automatic drive(input logic v, input logic [127:0] p, input int mode,
                       input logic [63:0] want, input logic ld,
                       input logic [63:0] lm, input logic [64:0] lmu);
    logic ok;
    exp_t e;
    ok = ld && (sb.size() == 0) && lm[63];
    if (ok) begin
      model_m     = lm;
      model_ready = 1'b1;
    end
    if (v && model_ready) begin
      e.due  = cyc + 5;
      e.chk  = (mode != 2);
      e.data = (mode == 1) ? want : 64'(p % {64'd0, model_m});
      e.e    = ERR_EN && (p[127:64] >= model_m);
      sb.push_back(e);
    end
    in_valid = v;
    in_data  = p;
    mod_load = ld;
    mod_in   = lm;
    mu_in    = lmu;
    tick();
    chk("load_err", 128'(load_err), 128'(ld && !ok));
    in_valid = 1'b0;
    mod_load = 1'b0;
  endtask

  task automatic beat(input logic [127:0] p);
    drive(1'b1, p, 0, 64'd0, 1'b0, 64'd0, 65'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 128'd0, 0, 64'd0, 1'b0, 64'd0, 65'd0);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({nm, "_out_data"},  128'(out_data),  128'd0);
    chk({nm, "_err"},       128'(err),       128'd0);
    chk({nm, "_load_err"},  128'(load_err),  128'd0);
    chk({nm, "_busy"},      128'(busy),      128'd0);
    chk({nm, "_mod_ready"}, 128'(mod_ready), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0]  mt1;
    logic [63:0]  m;
    logic [127:0] ones;

    cyc = 0; total = 0; bad = 0;
    model_ready = 1'b0;
    model_m     = 64'd0;
    mt1  = MT - 64'd1;
    ones = '1;

    vecs[0].p = 128'd1234 * 128'd5678;               vecs[0].want = 64'd7006652;
    vecs[1].p = 128'd0;                              vecs[1].want = 64'd0;
    vecs[2].p = {64'd0, MT};                         vecs[2].want = 64'd0;
    vecs[3].p = {64'd0, mt1} * {64'd0, mt1};         vecs[3].want = 64'd1;
    vecs[4].p = {64'd0, MT} * {64'd0, mt1};          vecs[4].want = 64'd0;

    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    mod_load = 1'b0; mod_in = '0; mu_in = '0;
    #3;
    check_all_zero("reset");
    tick();
    tick();
    reset = 1'b1;

    // Beats before any modulus is loaded are dropped.
    beat(128'd99);
    idle(6);

    // Load the reference modulus, then run the table vectors.
    drive(1'b0, 128'd0, 0, 64'd0, 1'b1, MT, MUT);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vecs[i].p, 1, vecs[i].want, 1'b0, 64'd0, 65'd0);
      if (i == 0) idle(5);
    end
    idle(6);

    // A load while busy is rejected, and in-flight beats keep using the old M.
    beat(rand_prod(MT));
    beat(rand_prod(MT));
    drive(1'b1, rand_prod(MT), 0, 64'd0, 1'b1, 64'h8000_0000_0000_0001,
          mu_of(64'h8000_0000_0000_0001));
    idle(6);

    // A load with a clear top bit is rejected while idle.
    drive(1'b0, 128'd0, 0, 64'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFC5, 65'd0);
    beat(128'd1234 * 128'd5678);
    beat({64'd0, MT} + 128'd5);
    idle(6);

    // An out-of-range product raises err only when the check is built.
    drive(1'b1, ones, 2, 64'd0, 1'b0, 64'd0, 65'd0);
    idle(6);

    // Random products. Each round loads a modulus together with the first beat.
    for (int r = 0; r < 6; r++) begin
      m = (r == 0) ? MT : rand_mod();
      drive(1'b1, rand_prod(m), 0, 64'd0, 1'b1, m, mu_of(m));
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(3) != 0) beat(rand_prod(m));
        else idle(1);
      end
      idle(6);
    end

    // Reset in the middle of three beats, with the second beat in S2.
    beat(rand_prod(model_m));
    beat(rand_prod(model_m));
    beat(rand_prod(model_m));
    reset = 1'b0;
    #1;
    sb.delete();
    model_ready = 1'b0;
    check_all_zero("mid_reset");
    tick();
    tick();
    reset = 1'b1;
    beat(128'd1234 * 128'd5678);
    idle(6);

    // Reload the modulus, after which beats are processed again.
    drive(1'b0, 128'd0, 0, 64'd0, 1'b1, MT, MUT);
    drive(1'b1, vecs[0].p, 1, vecs[0].want, 1'b0, 64'd0, 65'd0);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/barrett_reduce128.md
# barrett_reduce128

Pipelined Barrett reduction stage. It sits directly downstream of the `karatsuba32` 64×64 multiplier and consumes that block's 128-bit product `P` every cycle. It returns `P mod M` for a run-time-loaded 64-bit modulus `M`. Together the two blocks form the modular multiplier datapath: 3 cycles of multiply plus 4 cycles of reduction, fully pipelined, one result per cycle.

## Interface
Parameters:
- `W`, 64, modulus/result width; product width is `2*W`, mu width is `W+1`.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` carries a product this cycle.
- `in_data`  in  128  product `P` from the multiplier; required `P < M*M`.
- `mod_load`  in  1  load strobe for modulus and mu.
- `mod_in`  in  64  modulus `M`; `mod_in[63]` must be 1.
- `mu_in`  in  65  `floor(2^128 / M)`, precomputed by software.
- `mod_ready`  out  1  a modulus is loaded.
- `busy`  out  1  some pipeline stage holds a valid entry.
- `load_err`  out  1  one-cycle pulse when a `mod_load` is rejected.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  64  `P mod M`.
- `err`  out  1  result error flag (see Configuration).

## Operation
- The modulus registers `M` and `mu` are written on a clock edge where `mod_load=1`, `busy=0` and `mod_in[63]=1`. `mod_ready` is then set.
- A `mod_load` that fails either condition leaves `M`, `mu` and `mod_ready` unchanged and pulses `load_err` on the next cycle.
- An `in_valid` beat while `mod_ready=0` is dropped: it does not enter the pipe and produces no output.
- Arithmetic per entry (Barrett, k=64, b=2):
  - S1: register `P`; `q1 = P[127:63]` (65 b).
  - S2: `q3 = (q1*mu)[129:65]` (65 b); `r1 = P[64:0]`.
  - S3: `r2 = (q3*M)[64:0]`; `r = (r1 - r2) mod 2^65`.
  - S4: `if r>=M r-=M`, applied twice. `out_data = r[63:0]`.
- Each stage has its own valid bit, and the valid bits shift every cycle. There is no backpressure and no stall.
- `busy` is the OR of the S1–S4 valid bits.
- `M` and `mu` are static while `busy=1`, which the load rule guarantees. In-flight entries therefore never see a modulus change.

## Timing
- Latency is exactly 4 cycles: a product accepted at edge n gives `out_valid=1` and a valid `out_data` after edge n+4.
- Throughput is one product per cycle, and back-to-back beats produce back-to-back results in order.
- Reset values:
  - `out_valid`, `out_data`, `err`, `load_err`, `busy` and `mod_ready` are 0.
  - `M`, `mu` and all stage registers are 0.
- Reset asserted mid-operation discards all in-flight entries immediately, with no output. The modulus must be reloaded afterwards.
- Simultaneous `mod_load` and `in_valid` with `busy=0` and a valid modulus: the load takes effect on that edge, and the input beat is processed with the newly loaded `M`.
- Simultaneous `mod_load` and the last in-flight entry leaving S4 counts as `busy=1`. The load is rejected.

## Configuration
- `BARRETT_ERR_CHECK_EN` defined:
  - S1 flags the entry when `P[127:64] >= M`, a necessary condition for `P >= M*M`.
  - S4 flags the entry when `r >= M` after both corrections.
  - `err` is asserted together with `out_valid` for a flagged entry. `out_data` is still the computed value.
- Not defined: `err` is tied to 0 and no check logic is built.

## Test plan
All scenarios use `M=0xFFFFFFFFFFFFFFC5` and `mu=0x1_0000_0000_0000_003B` unless stated otherwise.
- Load M/mu, then push `P=1234*5678`. Required: `out_valid` exactly 4 cycles later with `out_data=7006652`, `err=0`.
- Push back-to-back `P=0`, `P=M`, `P=(M-1)^2`, `P=M*(M-1)`. Required: outputs on 4 consecutive cycles equal to 0, 0, 1, 0.
- Pulse `mod_load` with `mod_in=0x8000000000000001` while `busy=1`. Required: `load_err` pulses, in-flight results still use the old M, `mod_ready` stays 1.
- Pulse `mod_load` with `mod_in[63]=0`. Required: `load_err=1` and the modulus is unchanged.
- Push 3 beats, then assert `reset` low at the 2nd beat's S2. Required: all outputs are 0 immediately, no `out_valid` follows, `mod_ready=0`, and an `in_valid` after release is dropped until a reload.
- With `BARRETT_ERR_CHECK_EN`, push `P=2^128-1`. Required: `err=1` with `out_valid`. Without the macro: `err=0`.
